conv_enc_213: RTL

- Streaming rate-1/2 (2,1,3) convolutional encoder: 3-bit memory, 8 trellis states.
- Produces the 2-bit code symbols consumed downstream by the Viterbi branch-metric/ACS chain. Symbol bit order matches the HD inputs of that chain.
- Accepts one information bit per handshake and emits one registered code symbol per bit.
- Zero-terminates each frame with M=3 tail symbols, so the decoder always ends in state 0.

---
 rtl/conv_enc_213_if.sv | 24 ++
 rtl/conv_enc_213.sv | 106 ++++++++++
 2 files changed

// File: rtl/conv_enc_213_if.sv
// Streaming handshake bundle for the (2,1,3) convolutional encoder:
// information-bit input side and code-symbol output side.
interface conv_enc_213_if;
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [1:0] out_sym;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    // Producer of information bits / consumer of code symbols.
    modport master (
        output in_bit, in_valid, in_last, out_ready,
        input  in_ready, out_sym, out_valid, out_last
    );

    // The encoder itself.
    modport slave (
        input  in_bit, in_valid, in_last, out_ready,
        output in_ready, out_sym, out_valid, out_last
    );
endinterface

// File: rtl/conv_enc_213.sv
// Rate-1/2 (2,1,3) convolutional encoder with zero-tail frame termination.
// One registered code symbol {c_G0, c_G1} per accepted bit, plus 3 tail symbols.
module conv_enc_213 #(
    parameter logic [3:0] G0   = 4'b1111,
    parameter logic [3:0] G1   = 4'b1101,
    parameter int         CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    conv_enc_213_if.slave   bus,
    output logic            busy,
    output logic [CNTW-1:0] sym_count
);
    typedef enum logic {ENC, TAIL} state_t;

    state_t     state, state_nxt;
    logic [1:0] tail_cnt, tail_cnt_nxt;
    logic [2:0] sr, sr_nxt;
    logic       adv, load, u, tail_end, last_xfer, in_ready_c;
    logic [3:0] v;
    logic [1:0] code;

    function automatic logic tap_parity(input logic [3:0] g, input logic [3:0] x);
        return ^(g & x);
    endfunction

    // The single output register may be reloaded when empty or being drained.
    assign adv       = !bus.out_valid || bus.out_ready;
    assign last_xfer = bus.out_valid && bus.out_ready && bus.out_last;

    assign v    = {u, sr[0], sr[1], sr[2]};
    assign code = {tap_parity(G0, v), tap_parity(G1, v)};

    always_comb begin
        state_nxt    = state;
        tail_cnt_nxt = tail_cnt;
        in_ready_c   = 1'b0;
        load         = 1'b0;
        u            = 1'b0;
        tail_end     = 1'b0;
        case (state)
            ENC: begin
                in_ready_c = adv;
                u          = bus.in_bit;
                if (bus.in_valid && adv) begin
                    load = 1'b1;
                    if (bus.in_last) begin
                        state_nxt    = TAIL;
                        tail_cnt_nxt = 2'd0;
                    end
                end
            end
            TAIL: begin
                if (adv) begin
                    load         = 1'b1;
                    tail_cnt_nxt = tail_cnt + 2'd1;
                    if (tail_cnt == 2'd2) begin
                        tail_end     = 1'b1;
                        state_nxt    = ENC;
                        tail_cnt_nxt = 2'd0;
                    end
                end
            end
            default: state_nxt = ENC;
        endcase
        // Zero tail already flushes the memory; clearing it explicitly keeps
        // the next frame independent of any upset.
        sr_nxt = tail_end ? 3'b000 : {sr[1:0], u};
    end

    assign bus.in_ready = in_ready_c;
    assign busy         = (state == TAIL) || bus.out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENC;
            tail_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            tail_cnt <= tail_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr            <= 3'b000;
            bus.out_sym   <= 2'b00;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            sym_count     <= '0;
        end else if (load) begin
            sr            <= sr_nxt;
            bus.out_sym   <= code;
            bus.out_valid <= 1'b1;
            bus.out_last  <= tail_end;
            // A new frame starting as the previous last symbol leaves restarts at 1.
            sym_count     <= last_xfer ? CNTW'(1) : sym_count + CNTW'(1);
        end else begin
            if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
            if (last_xfer) sym_count <= '0;
        end
    end
endmodule
